svc_stream_gen: RTL and testbench
=================================

// Module: svc_stream_gen
// PURPOSE
// - Valid/ready stream source: transmit end of the same handshake a skid buffer receives.
// - On a start pulse, emits COUNT beats of arithmetic-sequence data (init, init+step, ...).
// - Obeys backpressure and reports completion.
// - Used as a traffic generator in front of buffers/FIFOs, and as a bench driver.
// PARAMETERS
// - DATA_WIDTH  8   width of m_data, data_init and data_step
// - CNT_WIDTH   16  width of the beat count; max transfer is 2^CNT_WIDTH-1 beats
// PORTS
// - clk        in   1           clock; all logic on posedge
// - rst        in   1           synchronous reset, active-high
// - start      in   1           one-cycle request; accepted only in IDLE
// - count      in   CNT_WIDTH   beats to send; sampled with start
// - data_init  in   DATA_WIDTH  first beat value; sampled with start
// - data_step  in   DATA_WIDTH  per-beat increment; sampled with start
// - busy       out  1           high whenever state != IDLE
// - done       out  1           one-cycle pulse after the final beat is accepted
// - m_valid    out  1           stream valid, registered
// - m_ready    in   1           stream ready from sink
// - m_data     out  DATA_WIDTH  stream data, registered
// BEHAVIOUR
// - Reset values: state=IDLE; busy=0, done=0, m_valid=0, m_data=0; remaining count=0.
// - States: IDLE, RUN, DONE.
//   - IDLE -> RUN on start && count!=0: latch count, step; m_data<=data_init; m_valid<=1.
//   - IDLE -> DONE on start && count==0: no beats emitted.
//   - RUN: handshake = m_valid && m_ready; each handshake decrements remaining.
//   - RUN: on a non-final handshake, m_data <= m_data + step (mod 2^DATA_WIDTH, wraps silently).
//   - RUN -> DONE on the handshake with remaining==1; m_valid<=0 that edge.
//   - DONE -> IDLE unconditionally after one cycle; done=1 only while in DONE.
// - Latency:
//   - start at edge N -> m_valid=1 from edge N, visible cycle N+1.
//   - last handshake at edge M -> done=1 in cycle M+1; busy low from cycle M+2.
// - Throughput: one beat per cycle while m_ready held high (no bubbles between beats).
// - Handshake rules:
//   - Once m_valid=1, m_valid and m_data hold stable until the handshake.
//   - m_valid never depends combinationally on m_ready.
// - start while busy (RUN or DONE) is ignored; inputs are not resampled.
// - count/data_init/data_step changes outside the start cycle have no effect.
// - Reset mid-transfer: next cycle m_valid=0, busy=0; unsent beats are discarded, no done pulse.
// - rst has priority over start in the same cycle.
// CONFIGURATION
// - SVC_STREAM_GEN_THROTTLE_EN: when defined, inserts pseudo-random bubbles.
//   - Adds a 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to 16'hACE1, advancing every cycle.
//   - Holding m_valid low: in RUN, a beat is presented (m_valid 0->1) only in a cycle with lfsr[0]==1.
//   - After each handshake: m_valid drops to 0 if lfsr[0]==0 that cycle.
//   - First beat: also gated by lfsr[0].
//   - Stability rule above still holds: a presented beat is never withdrawn.
//   - Sequence, count and done semantics are unchanged.
// - Undefined: no LFSR; behaviour exactly as above (no bubbles).
// TESTING
// - Basic: count=4, init=8'h10, step=8'h01, m_ready=1
//   -> beats 10,11,12,13 on 4 consecutive cycles; done one cycle after beat 13; busy then low.
// - Backpressure: count=3, init=8'hA0, step=8'h05, m_ready=0 for 3 cycles then 1
//   -> m_data holds A0 with m_valid=1 throughout the stall; then A5, AA; done once.
// - Wrap/zero: init=8'hFE, step=8'h01, count=3 -> FE, FF, 00.
// - Wrap/zero: count=0 -> no m_valid; done=1 in the cycle after start.
// - Start while busy: pulse start (count=9) mid-transfer of count=2
//   -> exactly 2 beats emitted; second start ignored.
// - Reset mid-op: count=8, rst=1 after 3rd handshake
//   -> next cycle m_valid=0, busy=0, done=0; a new start afterwards begins from its own data_init.
// - Throttle build: with SVC_STREAM_GEN_THROTTLE_EN, count=16, m_ready=1
//   -> 16 ordered beats with at least one bubble; m_data stable whenever m_valid && !m_ready.

Source files
------------

// File: rtl/svc_stream_gen.sv
// rtl/svc_stream_gen.sv - valid/ready source emitting COUNT beats of an arithmetic sequence
// Optional pseudo-random bubble insertion is enabled by defining SVC_STREAM_GEN_THROTTLE_EN.
module svc_stream_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [DATA_WIDTH-1:0] data_init,
  input  logic [DATA_WIDTH-1:0] data_step,
  output logic                  busy,
  output logic                  done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [DATA_WIDTH-1:0] step_q, step_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  present;
  logic                  hs;

`ifdef SVC_STREAM_GEN_THROTTLE_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign present = lfsr_q[0];
`else
  assign present = 1'b1;
`endif

  assign hs = valid_q & m_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    step_d  = step_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            state_d = RUN;
            rem_d   = count;
            step_d  = data_step;
            data_d  = data_init;
            valid_d = present;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // A presented beat is only ever lowered by its own handshake.
        if (hs) begin
          rem_d = rem_q - CNT_WIDTH'(1);
          if (rem_q == CNT_WIDTH'(1)) begin
            state_d = DONE;
            valid_d = 1'b0;
          end else begin
            data_d  = data_q + step_q;
            valid_d = present;
          end
        end else if (!valid_q) begin
          valid_d = present;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      step_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign m_valid = valid_q;
  assign m_data  = data_q;

endmodule

// File: tb/tb_svc_stream_gen.sv
// tb/tb_svc_stream_gen.sv - self-checking bench for svc_stream_gen
module tb_svc_stream_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] count;
  logic [7:0]  data_init;
  logic [7:0]  data_step;
  logic        busy;
  logic        done;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  svc_stream_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .data_init (data_init),
    .data_step (data_step),
    .busy      (busy),
    .done      (done),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
  );

  typedef struct {
    int         cnt;
    logic [7:0] init;
    logic [7:0] step;
    int         stall;
    int         exp_beats;
    logic [7:0] exp_last;
    int         exp_done_k;
  } vec_t;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected beat i of a transfer: init + i*step, modulo 256.
  function automatic logic [7:0] model_beat(input logic [7:0] init, input logic [7:0] step, input int i);
    int v;
    v = (int'(init) + i * int'(step)) % 256;
    return v[7:0];
  endfunction

  // k counts negedges after the edge that samples start (k=1 is the first cycle after start).
  task automatic run_xfer(input int cnt, input logic [7:0] init, input logic [7:0] step,
                          input int stall, input bit rnd, input int inject_k, input string tag,
                          output int nbeats, output logic [7:0] last, output int done_k);
    int         ndone;
    int         last_hs_k;
    int         k;
    bit         prev_stall;
    logic [7:0] prev_data;
    nbeats = 0; last = 8'h00; done_k = -1; ndone = 0; last_hs_k = 0;
    prev_stall = 1'b0; prev_data = 8'h00;
    @(negedge clk);
    start = 1'b1; count = cnt[15:0]; data_init = init; data_step = step; m_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    count = 16'($urandom); data_init = 8'($urandom); data_step = 8'($urandom);
    k = 1;
    while (k < 3000) begin
      start = (k == inject_k);
      if (start) begin
        count = 16'd9; data_init = 8'h99;
      end
      if (prev_stall)
        chk(m_valid === 1'b1 && m_data === prev_data, {tag, " stable"}, {m_valid, m_data}, {1'b1, prev_data});
`ifndef SVC_STREAM_GEN_THROTTLE_EN
      if (nbeats < cnt)
        chk(m_valid === 1'b1, {tag, " no_bubble"}, m_valid, 1);
`endif
      m_ready = rnd ? ($urandom_range(0, 3) != 0) : (k > stall);
      if (m_valid === 1'b1 && m_ready) begin
        chk(nbeats < cnt && m_data === model_beat(init, step, nbeats),
            $sformatf("%s beat%0d", tag, nbeats), m_data, model_beat(init, step, nbeats));
        nbeats++;
        last = m_data;
        last_hs_k = k;
      end
      prev_stall = (m_valid === 1'b1) && !m_ready;
      prev_data  = m_data;
      if (done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 1) break;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (done_k < 0) begin
      chk(1'b0, {tag, " timeout"}, k, 0);
    end else begin
      chk(busy === 1'b0 && m_valid === 1'b0, {tag, " idle_after_done"}, {busy, m_valid}, 0);
      chk(ndone == 1, {tag, " done_pulses"}, ndone, 1);
      chk(done_k == last_hs_k + 1, {tag, " done_latency"}, done_k, last_hs_k + 1);
    end
    chk(nbeats == cnt, {tag, " beat_count"}, nbeats, cnt);
  endtask

  vec_t       vecs[6];
  int         nb;
  int         dk;
  int         hs;
  logic [7:0] lst;

  initial begin
    vecs[0] = '{4, 8'h10, 8'h01, 0, 4, 8'h13, 5};
    vecs[1] = '{3, 8'hA0, 8'h05, 3, 3, 8'hAA, 7};
    vecs[2] = '{3, 8'hFE, 8'h01, 0, 3, 8'h00, 4};
    vecs[3] = '{0, 8'h55, 8'h01, 0, 0, 8'h00, 1};
    vecs[4] = '{1, 8'h7F, 8'h80, 2, 1, 8'h7F, 4};
    vecs[5] = '{5, 8'hF0, 8'h40, 1, 5, 8'hF0, 7};

    rst = 1'b1; start = 1'b0; count = '0; data_init = '0; data_step = '0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(busy === 1'b0 && done === 1'b0 && m_valid === 1'b0 && m_data === 8'h00,
        "reset_state", {busy, done, m_valid, m_data}, 0);

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].cnt, vecs[i].init, vecs[i].step, vecs[i].stall, 1'b0, -1,
               $sformatf("vec%0d", i), nb, lst, dk);
      chk(nb == vecs[i].exp_beats, $sformatf("vec%0d nbeats", i), nb, vecs[i].exp_beats);
      chk(lst === vecs[i].exp_last, $sformatf("vec%0d last", i), lst, vecs[i].exp_last);
`ifndef SVC_STREAM_GEN_THROTTLE_EN
      chk(dk == vecs[i].exp_done_k, $sformatf("vec%0d done_k", i), dk, vecs[i].exp_done_k);
`endif
    end

    // start pulses while RUN and while DONE must both be ignored
    run_xfer(2, 8'h20, 8'h01, 0, 1'b0, 1, "busy_start_run", nb, lst, dk);
    run_xfer(2, 8'h30, 8'h01, 0, 1'b0, 3, "busy_start_done", nb, lst, dk);
    repeat (3) begin
      @(negedge clk);
      chk(busy === 1'b0 && m_valid === 1'b0, "no_late_start", {busy, m_valid}, 0);
    end

    // reset after the third handshake of an 8-beat transfer
    @(negedge clk);
    start = 1'b1; count = 16'd8; data_init = 8'h40; data_step = 8'h02; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hs = 0;
    for (int k = 0; k < 200 && hs < 3; k++) begin
      if (m_valid === 1'b1) hs++;
      if (hs < 3) @(negedge clk);
    end
    chk(hs == 3, "rst_mid_handshakes", hs, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk(m_valid === 1'b0 && busy === 1'b0 && done === 1'b0 && m_data === 8'h00,
        "rst_mid_state", {m_valid, busy, done, m_data}, 0);
    repeat (3) begin
      @(negedge clk);
      chk(done === 1'b0 && m_valid === 1'b0, "rst_mid_no_done", {done, m_valid}, 0);
    end
    run_xfer(2, 8'h77, 8'h03, 0, 1'b0, -1, "after_rst", nb, lst, dk);
    chk(lst === 8'h7A, "after_rst last", lst, 8'h7A);

    // reset has priority over a simultaneous start
    @(negedge clk);
    rst = 1'b1; start = 1'b1; count = 16'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk(busy === 1'b0 && m_valid === 1'b0, "rst_prio", {busy, m_valid}, 0);
    @(negedge clk);
    chk(busy === 1'b0 && m_valid === 1'b0, "rst_prio_hold", {busy, m_valid}, 0);

    // randomized transfers with random backpressure
    for (int t = 0; t < 20; t++) begin
      run_xfer($urandom_range(0, 12), 8'($urandom), 8'($urandom), 0, 1'b1, -1,
               $sformatf("rnd%0d", t), nb, lst, dk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
